// File: rtl/ibex_clintx_irq_ctrl_pkg.sv
// Shared types and constants for the CLINTx extended interrupt front end.
package ibex_clintx_irq_ctrl_pkg;

  localparam int unsigned CLINTX_NUM_IRQ = 32;
  localparam int unsigned CLINTX_ID_W    = 5;

  typedef enum logic [1:0] {
    CLINTX_IDLE,
    CLINTX_REQ,
    CLINTX_ACKD
  } clintx_irq_state_e;

  typedef enum logic [5:0] {
    EXC_CAUSE_NONE     = 6'h00,
    EXC_CAUSE_IRQ_X_0  = 6'h20, EXC_CAUSE_IRQ_X_1  = 6'h21, EXC_CAUSE_IRQ_X_2  = 6'h22,
    EXC_CAUSE_IRQ_X_3  = 6'h23, EXC_CAUSE_IRQ_X_4  = 6'h24, EXC_CAUSE_IRQ_X_5  = 6'h25,
    EXC_CAUSE_IRQ_X_6  = 6'h26, EXC_CAUSE_IRQ_X_7  = 6'h27, EXC_CAUSE_IRQ_X_8  = 6'h28,
    EXC_CAUSE_IRQ_X_9  = 6'h29, EXC_CAUSE_IRQ_X_10 = 6'h2A, EXC_CAUSE_IRQ_X_11 = 6'h2B,
    EXC_CAUSE_IRQ_X_12 = 6'h2C, EXC_CAUSE_IRQ_X_13 = 6'h2D, EXC_CAUSE_IRQ_X_14 = 6'h2E,
    EXC_CAUSE_IRQ_X_15 = 6'h2F, EXC_CAUSE_IRQ_X_16 = 6'h30, EXC_CAUSE_IRQ_X_17 = 6'h31,
    EXC_CAUSE_IRQ_X_18 = 6'h32, EXC_CAUSE_IRQ_X_19 = 6'h33, EXC_CAUSE_IRQ_X_20 = 6'h34,
    EXC_CAUSE_IRQ_X_21 = 6'h35, EXC_CAUSE_IRQ_X_22 = 6'h36, EXC_CAUSE_IRQ_X_23 = 6'h37,
    EXC_CAUSE_IRQ_X_24 = 6'h38, EXC_CAUSE_IRQ_X_25 = 6'h39, EXC_CAUSE_IRQ_X_26 = 6'h3A,
    EXC_CAUSE_IRQ_X_27 = 6'h3B, EXC_CAUSE_IRQ_X_28 = 6'h3C, EXC_CAUSE_IRQ_X_29 = 6'h3D,
    EXC_CAUSE_IRQ_X_30 = 6'h3E, EXC_CAUSE_IRQ_X_31 = 6'h3F
  } exc_cause_e;

  function automatic exc_cause_e clintx_cause(logic [CLINTX_ID_W-1:0] id);
    return exc_cause_e'({1'b1, id});
  endfunction

endpackage

// File: rtl/ibex_clintx_prio_enc.sv
// Lowest-index-wins priority encoder: index 0 has the highest priority.
module ibex_clintx_prio_enc #(
  parameter int unsigned Width = 32,
  parameter int unsigned IdW   = 5
) (
  input  logic [Width-1:0] in_i,
  output logic             valid_o,
  output logic [IdW-1:0]   id_o
);

  always_comb begin
    valid_o = |in_i;
    id_o    = '0;
    // Scan from the top so the lowest set index is the last to write.
    for (int unsigned i = Width; i > 0; i--) begin
      if (in_i[i-1]) id_o = IdW'(i - 1);
    end
  end

endmodule

// File: rtl/ibex_clintx_irq_ctrl.sv
// CLINTx extended interrupt front end: sync, pending/MIEX masking, arbitration, held request.
// Optional per-line edge mode is built with IBEX_CLINTX_EDGE_EN.
module ibex_clintx_irq_ctrl
  import ibex_clintx_irq_ctrl_pkg::*;
#(
  parameter int unsigned NumIrqX    = 32,
  parameter int unsigned SyncStages = 2
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NumIrqX-1:0] irq_x_i,
  input  logic [31:0]        mie_x_i,
  input  logic [31:0]        mip_x_clr_i,
  output logic [31:0]        mip_x_o,
  output logic               irq_x_req_o,
  output logic [4:0]         irq_x_id_o,
  output logic [5:0]         irq_x_cause_o,
`ifdef IBEX_CLINTX_EDGE_EN
  input  logic [31:0]        irq_x_edge_i,
`endif
  input  logic               irq_x_ack_i
);

  logic [NumIrqX-1:0]     sync_q [SyncStages];
  logic [NumIrqX-1:0]     sync;
  logic [31:0]            pending_q, pending_d;
  logic [31:0]            active;
  logic                   win_valid;
  logic [CLINTX_ID_W-1:0] win_id;

  clintx_irq_state_e      state_q;
  logic                   req_q;
  logic [CLINTX_ID_W-1:0] id_q;
  logic [5:0]             cause_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned s = 0; s < SyncStages; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= irq_x_i;
      for (int unsigned s = 1; s < SyncStages; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign sync = sync_q[SyncStages-1];

`ifdef IBEX_CLINTX_EDGE_EN
  logic [NumIrqX-1:0] sync_prev_q;
  logic [NumIrqX-1:0] rise, edge_sel, clr;
  logic [31:0]        ack_clr;
  logic               unused_in;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sync_prev_q <= '0;
    else         sync_prev_q <= sync;
  end

  assign rise     = sync & ~sync_prev_q;
  assign edge_sel = irq_x_edge_i[NumIrqX-1:0];
  assign ack_clr  = (state_q == CLINTX_ACKD) ? (32'd1 << id_q) : '0;
  assign clr      = mip_x_clr_i[NumIrqX-1:0] | ack_clr[NumIrqX-1:0];
  assign unused_in = ^{mip_x_clr_i, mie_x_i, irq_x_edge_i, ack_clr};

  // Edge bits are sticky; a new rising edge outranks any clear in the same cycle.
  always_comb begin
    pending_d = '0;
    pending_d[NumIrqX-1:0] = (~edge_sel & sync) |
                             (edge_sel & (rise | (pending_q[NumIrqX-1:0] & ~clr)));
  end
`else
  logic unused_in;
  assign unused_in = ^{mip_x_clr_i, mie_x_i};

  always_comb begin
    pending_d = '0;
    pending_d[NumIrqX-1:0] = sync;
  end
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) pending_q <= '0;
    else         pending_q <= pending_d;
  end

  always_comb begin
    active = '0;
    active[NumIrqX-1:0] = pending_q[NumIrqX-1:0] & mie_x_i[NumIrqX-1:0];
  end

  ibex_clintx_prio_enc #(
    .Width (CLINTX_NUM_IRQ),
    .IdW   (CLINTX_ID_W)
  ) u_prio_enc (
    .in_i    (active),
    .valid_o (win_valid),
    .id_o    (win_id)
  );

  // ID stays latched through ACKD so the edge-mode pending bit can be cleared.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= CLINTX_IDLE;
      req_q   <= 1'b0;
      id_q    <= '0;
      cause_q <= '0;
    end else begin
      unique case (state_q)
        CLINTX_IDLE: begin
          if (win_valid) begin
            state_q <= CLINTX_REQ;
            req_q   <= 1'b1;
            id_q    <= win_id;
            cause_q <= clintx_cause(win_id);
          end else begin
            req_q   <= 1'b0;
            id_q    <= '0;
            cause_q <= '0;
          end
        end
        CLINTX_REQ: begin
          if (irq_x_ack_i) begin
            state_q <= CLINTX_ACKD;
            req_q   <= 1'b0;
          end else if (!active[id_q]) begin
            state_q <= CLINTX_IDLE;
            req_q   <= 1'b0;
            id_q    <= '0;
            cause_q <= '0;
          end
        end
        default: begin
          state_q <= CLINTX_IDLE;
          req_q   <= 1'b0;
          id_q    <= '0;
          cause_q <= '0;
        end
      endcase
    end
  end

  assign mip_x_o       = pending_q;
  assign irq_x_req_o   = req_q;
  assign irq_x_id_o    = id_q;
  assign irq_x_cause_o = cause_q;

endmodule

// File: tb/tb_ibex_clintx_irq_ctrl.sv
// Directed self-checking bench for ibex_clintx_irq_ctrl (edge tests need IBEX_CLINTX_EDGE_EN).
module tb_ibex_clintx_irq_ctrl;

  logic        clk;
  logic        rst_n;
  logic [31:0] irq_x;
  logic [31:0] mie_x;
  logic [31:0] mip_clr;
  logic [31:0] mip_x;
  logic        req;
  logic [4:0]  id;
  logic [5:0]  cause;
  logic        ack;
`ifdef IBEX_CLINTX_EDGE_EN
  logic [31:0] edge_sel;
`endif

  int checks   = 0;
  int failures = 0;

  ibex_clintx_irq_ctrl #(
    .NumIrqX    (32),
    .SyncStages (2)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .irq_x_i       (irq_x),
    .mie_x_i       (mie_x),
    .mip_x_clr_i   (mip_clr),
    .mip_x_o       (mip_x),
    .irq_x_req_o   (req),
    .irq_x_id_o    (id),
    .irq_x_cause_o (cause),
`ifdef IBEX_CLINTX_EDGE_EN
    .irq_x_edge_i  (edge_sel),
`endif
    .irq_x_ack_i   (ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_out(input string tag, input logic r, input logic [4:0] i, input logic [5:0] c);
    chk({tag, "_req"}, {31'd0, req}, {31'd0, r});
    chk({tag, "_id"}, {27'd0, id}, {27'd0, i});
    chk({tag, "_cause"}, {26'd0, cause}, {26'd0, c});
  endtask

  task automatic quiesce();
    mie_x = '0; irq_x = '0; ack = 1'b0; mip_clr = '0;
    step(5);
  endtask

  initial begin
    rst_n = 1'b0; irq_x = '0; mie_x = '0; mip_clr = '0; ack = 1'b0;
`ifdef IBEX_CLINTX_EDGE_EN
    edge_sel = '0;
`endif
    step(3);
    chk_out("in_reset", 1'b0, 5'd0, 6'd0);
    rst_n = 1'b1;
    step(2);
    chk_out("post_reset", 1'b0, 5'd0, 6'd0);
    chk("post_reset_mip", mip_x, 32'h0);

    // Line 5: three cycles to mip, request one cycle later.
    irq_x = 32'h20; mie_x = 32'h20;
    step(2);
    chk("l5_mip_early", mip_x, 32'h0);
    step(1);
    chk("l5_mip", mip_x, 32'h20);
    chk("l5_req_early", {31'd0, req}, 32'd0);
    step(1);
    chk_out("l5_req", 1'b1, 5'd5, 6'h25);
    ack = 1'b1;
    step(1);
    ack = 1'b0;
    chk("l5_ackd_req", {31'd0, req}, 32'd0);
    step(1);
    chk_out("l5_idle", 1'b0, 5'd0, 6'd0);
    step(1);
    chk_out("l5_rereq", 1'b1, 5'd5, 6'h25);
    quiesce();

    // Lines 9 and 2 together: 2 wins; drop 2 then ack; 9 follows.
    irq_x = 32'h204; mie_x = 32'hFFFF_FFFF;
    step(3);
    chk("p92_mip", mip_x, 32'h204);
    step(1);
    chk_out("p92_req", 1'b1, 5'd2, 6'h22);
    irq_x = 32'h200;
    step(2);
    chk_out("p92_hold", 1'b1, 5'd2, 6'h22);
    ack = 1'b1;
    step(1);
    ack = 1'b0;
    chk("p92_ackd", {31'd0, req}, 32'd0);
    step(1);
    chk_out("p92_idle", 1'b0, 5'd0, 6'd0);
    step(1);
    chk_out("p9_req", 1'b1, 5'd9, 6'h29);

    // Higher-priority line 1 arrives while 9 is held.
    irq_x = 32'h202;
    step(5);
    chk_out("p9_no_rearb", 1'b1, 5'd9, 6'h29);
    ack = 1'b1;
    step(1);
    ack = 1'b0;
    step(2);
    chk_out("p1_req", 1'b1, 5'd1, 6'h21);

    // Mask withdrawal: straight to IDLE, then 9 requested next cycle.
    mie_x = ~32'h2;
    step(1);
    chk_out("withdraw", 1'b0, 5'd0, 6'd0);
    step(1);
    chk_out("withdraw_next", 1'b1, 5'd9, 6'h29);

    // Ack and mask drop together: ACKD taken (extra cycle before the next request).
    ack = 1'b1; mie_x = 32'h2;
    step(1);
    ack = 1'b0;
    chk("ackfall_ackd", {31'd0, req}, 32'd0);
    step(1);
    chk_out("ackfall_idle", 1'b0, 5'd0, 6'd0);
    step(1);
    chk_out("ackfall_next", 1'b1, 5'd1, 6'h21);
    quiesce();

    // Stray ack in IDLE.
    chk("quiet_mip", mip_x, 32'h0);
    ack = 1'b1;
    step(1);
    chk_out("stray_ack", 1'b0, 5'd0, 6'd0);
    ack = 1'b0;
    step(1);
    chk_out("stray_ack_after", 1'b0, 5'd0, 6'd0);

    // Reset mid-request drops everything immediately.
    irq_x = 32'h20; mie_x = 32'h20;
    step(4);
    chk("rst_pre_req", {31'd0, req}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk_out("rst_mid", 1'b0, 5'd0, 6'd0);
    chk("rst_mid_mip", mip_x, 32'h0);
    step(2);
    rst_n = 1'b1;
    quiesce();

`ifdef IBEX_CLINTX_EDGE_EN
    // Edge line 4: one-cycle pulse stays pending until ack.
    edge_sel = 32'h10; mie_x = 32'h10;
    irq_x = 32'h10;
    step(1);
    irq_x = '0;
    step(2);
    chk("e4_mip", mip_x, 32'h10);
    step(1);
    chk_out("e4_req", 1'b1, 5'd4, 6'h24);
    step(4);
    chk("e4_sticky", mip_x, 32'h10);
    chk("e4_hold_req", {31'd0, req}, 32'd1);
    ack = 1'b1;
    step(1);
    ack = 1'b0;
    step(1);
    chk("e4_ack_clr", mip_x, 32'h0);
    step(1);
    chk("e4_no_rereq", {31'd0, req}, 32'd0);

    // CSR clear, then clear colliding with a new edge.
    mie_x = '0;
    irq_x = 32'h10;
    step(1);
    irq_x = '0;
    step(3);
    chk("e4_csr_set", mip_x, 32'h10);
    mip_clr = 32'h10;
    step(1);
    mip_clr = '0;
    chk("e4_csr_clr", mip_x, 32'h0);
    irq_x = 32'h10;
    step(1);
    irq_x = '0;
    step(1);
    mip_clr = 32'h10;
    step(1);
    mip_clr = '0;
    chk("e4_set_wins", mip_x, 32'h10);
    step(1);
    chk("e4_set_wins_hold", mip_x, 32'h10);
    quiesce();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ibex_clintx_irq_ctrl.md
Name: ibex_clintx_irq_ctrl

Overview:
- Front end for the CLINTx extended interrupt lines. It sits between the external irq_x sources and the core's ID/controller stage.
- Synchronises the lines, latches them into a pending vector (reported to the MIPX CSR) and masks it with MIEX.
- Arbitrates one winner and presents it as a held request, with 5-bit ID and exc_cause_e, until the core acknowledges the trap entry.

Parameters:
- NumIrqX, 32, number of implemented extended lines (1..32); unimplemented IDs read 0 everywhere.
- SyncStages, 2, flop stages in each input synchroniser (min 2).

Ports:
- clk_i  in  1  core clock.
- rst_ni  in  1  asynchronous active-low reset.
- irq_x_i  in  NumIrqX  raw external interrupt lines, asynchronous to clk_i.
- mie_x_i  in  32  MIEX CSR value; per-line enable.
- mip_x_clr_i  in  32  one-cycle clear strobe from a CSR write to MIPX; affects edge-latched bits only.
- mip_x_o  out  32  pending vector (unmasked), read by MIPX.
- irq_x_req_o  out  1  request to controller.
- irq_x_id_o  out  5  winning line ID.
- irq_x_cause_o  out  6  exc_cause_e, {1'b1, irq_x_id_o}.
- irq_x_ack_i  in  1  controller has taken the trap for irq_x_id_o.
- irq_x_edge_i  in  32  per-line edge-mode select. Present only with IBEX_CLINTX_EDGE_EN.

Behaviour:
- Reset (asynchronous, rst_ni low):
  - synchronisers, pending, FSM state and all outputs are 0; FSM is IDLE.
  - reset mid-request drops irq_x_req_o in the same cycle, with no ack needed.
- Synchroniser: SyncStages flops per line; output is sync[i].
- Pending, level line: pending[i] <= sync[i], combined with the edge update rule below when the macro is enabled.
- mip_x_o = pending register. A raw-input change appears on mip_x_o SyncStages+1 cycles later (3 with the default).
- Active vector: active = pending & mie_x_i[NumIrqX-1:0].
- Arbitration: lowest index wins (ID 0 highest priority), combinational over active.
- FSM states: IDLE, REQ, ACKD.
  - IDLE: if active != 0, register winner ID, go to REQ.
  - REQ: irq_x_req_o = 1. irq_x_id_o and irq_x_cause_o are held stable, with no re-arbitration while in REQ; a higher-priority arrival waits.
  - REQ, ack: on irq_x_ack_i go to ACKD.
  - REQ, withdrawal: if active[id] falls (line dropped or MIEX bit cleared) with no ack that cycle, deassert req and go to IDLE.
  - REQ, ack and fall in the same cycle: the ack wins and the FSM goes to ACKD.
  - ACKD: one cycle, req = 0. Clears pending[id] if that line is edge-mode. Then go to IDLE.
- Re-request latency:
  - level line still high after ACKD: re-requested 1 cycle after ACKD.
  - any new request: irq_x_req_o rises the cycle after IDLE sees active != 0.
- irq_x_ack_i while not in REQ is ignored, with no state change.
- Output timing: irq_x_id_o and irq_x_cause_o are registered, and are 0 whenever state is IDLE.
- mip_x_clr_i on level-mode bits has no effect, because level pending tracks the line.
- Any NumIrqX < 32 leaves upper pending, active and clear bits tied to 0.

Optional Feature:
- Macro: IBEX_CLINTX_EDGE_EN.
- Enabled:
  - irq_x_edge_i port exists and selects edge mode per line.
  - Edge mode detects a rising edge (sync & ~sync_q) and sets a sticky pending bit.
  - Clearing: the bit clears on ACKD for that ID, or on mip_x_clr_i[i].
  - Set and clear in the same cycle: set wins.
- Disabled: the port is absent, all lines are level mode, and the edge flops are not instantiated.

Decomposition:
- ibex_pkg additions:
  - CLINTX_NUM_IRQ = 32 and CLINTX_ID_W = 5.
  - typedef enum for FSM state clintx_irq_state_e {CLINTX_IDLE, CLINTX_REQ, CLINTX_ACKD}.
  - Cause formation reuses exc_cause_e (EXC_CAUSE_IRQ_X_*).
- One sub-module: ibex_clintx_prio_enc, a parameterised lowest-index priority encoder (32-bit to valid + 5-bit ID).

Test Plan:
- Reset release with irq_x_i = 0 -> all outputs 0. Raise irq_x_i[5] with mie_x_i[5] = 1 -> mip_x_o = 0x20 after 3 cycles; req = 1, id = 5, cause = 6'h25 one cycle later.
- Lines 9 and 2 pending and enabled together -> id = 2. Ack -> ACKD. With line 2 dropped, next request id = 9.
- In REQ with id = 9, assert line 1 -> id stays 9 until ack. Then id = 1.
- In REQ, clear mie_x_i[id] without ack -> req falls next cycle, no ACKD. Ack and mask drop in the same cycle -> ACKD taken.
- IBEX_CLINTX_EDGE_EN, edge line 4, 1-cycle pulse -> pending[4] stays 1 until ack. Separately, mip_x_clr_i[4] clears it, and a simultaneous new edge keeps it set.
- Deassert rst_ni while in REQ -> req, id, cause and mip_x_o are 0 immediately. A stray irq_x_ack_i in IDLE changes nothing.
